// File: rtl/pt_rd_responder.sv
// rtl/pt_rd_responder.sv - page-table read responder between a page-table walker and a host read port
//
// Purpose:
//   Accepts page-table cache-line read requests, forwards each to the host read
//   port tagged with a local slot index, and returns host data to the walker
//   with the walker's original tag. Unknown or stale host tags are dropped and
//   flagged on a sticky error bit.
//
// Build option:
//   PT_RESP_REORDER_EN - defined: responses leave in request-accept order,
//                        buffered per slot (2-cycle minimum latency).
//                        undefined: responses leave in host arrival order,
//                        slot freed on arrival (1-cycle latency, no data buffer).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   pt_tx_rd_addr/tag/valid/ready   walker request channel
//   pt_rx_data/rd_tag/rd_valid      walker response channel (no backpressure)
//   host_rd_addr/tag/valid/ready    host read request channel (tag = slot index)
//   host_rx_data/tag/valid          host response channel (no backpressure)
//   outstanding_cnt                 number of slots in use
//   tag_error                       sticky flag for dropped host responses

`ifndef PAGETABLE_TAG
`define PAGETABLE_TAG [15:0]
`endif

module pt_rd_responder #(
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          pt_tx_rd_addr,
    input  logic `PAGETABLE_TAG  pt_tx_rd_tag,
    input  logic                 pt_tx_rd_valid,
    output logic                 pt_tx_rd_ready,
    output logic [255:0]         pt_rx_data,
    output logic `PAGETABLE_TAG  pt_rx_rd_tag,
    output logic                 pt_rx_rd_valid,
    output logic [31:0]          host_rd_addr,
    output logic [7:0]           host_rd_tag,
    output logic                 host_rd_valid,
    input  logic                 host_rd_ready,
    input  logic [255:0]         host_rx_data,
    input  logic [7:0]           host_rx_tag,
    input  logic                 host_rx_valid,
    output logic [4:0]           outstanding_cnt,
    output logic                 tag_error
);

    localparam int IDXW = $clog2(MAX_OUTSTANDING);

    // Slot state: r_pend = allocated and still waiting for host data.
    logic [MAX_OUTSTANDING-1:0]  r_pend;
    logic `PAGETABLE_TAG         r_tag [MAX_OUTSTANDING];
    logic [IDXW-1:0]             r_alloc_ptr;
    logic [4:0]                  r_cnt;

    logic                        r_host_valid;
    logic [31:0]                 r_host_addr;
    logic [7:0]                  r_host_tag;

    logic                        r_rx_valid;
    logic [255:0]                r_rx_data;
    logic `PAGETABLE_TAG         r_rx_tag;
    logic                        r_tag_error;

    logic                        w_accept;
    logic [IDXW-1:0]             w_alloc_slot;
    logic [IDXW-1:0]             w_rx_idx;
    logic                        w_rx_ok;
    logic                        w_rx_bad;
    logic                        w_retire;
    logic [IDXW-1:0]             w_ret_slot;
    logic [255:0]                w_ret_data;

    // Gated by rst_n so ready is low throughout reset and rises as soon as
    // reset releases.
    assign pt_tx_rd_ready = rst_n & (r_cnt < 5'(MAX_OUTSTANDING))
                            & (~r_host_valid | host_rd_ready);
    assign w_accept = pt_tx_rd_valid & pt_tx_rd_ready;

    // A host tag is legal only if its upper bits are clear and it names a
    // slot still waiting for data; duplicates and late arrivals are dropped.
    assign w_rx_idx = host_rx_tag[IDXW-1:0];
    assign w_rx_ok  = host_rx_valid & ((host_rx_tag >> IDXW) == 8'd0) & r_pend[w_rx_idx];
    assign w_rx_bad = host_rx_valid & ~w_rx_ok;

`ifdef PT_RESP_REORDER_EN
    // Slots retire strictly in allocation order, so the slot at the
    // allocation pointer is always free whenever the count allows a request.
    logic [MAX_OUTSTANDING-1:0]  r_have;
    logic [IDXW-1:0]             r_ret_ptr;
    logic [255:0]                r_data [MAX_OUTSTANDING];

    assign w_alloc_slot = r_alloc_ptr;
    assign w_retire     = r_have[r_ret_ptr];
    assign w_ret_slot   = r_ret_ptr;
    assign w_ret_data   = r_data[r_ret_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_have    <= '0;
            r_ret_ptr <= '0;
        end else begin
            if (w_rx_ok) begin
                r_have[w_rx_idx] <= 1'b1;
            end
            if (w_retire) begin
                r_have[r_ret_ptr] <= 1'b0;
                r_ret_ptr         <= r_ret_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_rx_ok) begin
            r_data[w_rx_idx] <= host_rx_data;
        end
    end
`else
    // Slots free out of order, so take the first free slot at or after the
    // allocation pointer; with in-order returns this is simply the pointer.
    logic w_found;

    always_comb begin
        w_alloc_slot = r_alloc_ptr;
        w_found      = 1'b0;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (!w_found && !r_pend[r_alloc_ptr + IDXW'(i)]) begin
                w_alloc_slot = r_alloc_ptr + IDXW'(i);
                w_found      = 1'b1;
            end
        end
    end

    assign w_retire   = w_rx_ok;
    assign w_ret_slot = w_rx_idx;
    assign w_ret_data = host_rx_data;
`endif

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag[w_alloc_slot] <= pt_tx_rd_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend       <= '0;
            r_alloc_ptr  <= '0;
            r_cnt        <= '0;
            r_host_valid <= 1'b0;
            r_host_addr  <= '0;
            r_host_tag   <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_data    <= '0;
            r_rx_tag     <= '0;
            r_tag_error  <= 1'b0;
        end else begin
            // Arrival clears first; allocation never targets a pending slot.
            if (w_rx_ok) begin
                r_pend[w_rx_idx] <= 1'b0;
            end
            if (w_accept) begin
                r_pend[w_alloc_slot] <= 1'b1;
                r_alloc_ptr          <= w_alloc_slot + 1'b1;
                r_host_valid         <= 1'b1;
                r_host_addr          <= pt_tx_rd_addr;
                r_host_tag           <= {{(8-IDXW){1'b0}}, w_alloc_slot};
            end else if (host_rd_ready) begin
                r_host_valid <= 1'b0;
            end

            r_cnt <= r_cnt + {4'd0, w_accept} - {4'd0, w_retire};

            r_rx_valid <= w_retire;
            if (w_retire) begin
                r_rx_data <= w_ret_data;
                r_rx_tag  <= r_tag[w_ret_slot];
            end

            if (w_rx_bad) begin
                r_tag_error <= 1'b1;
            end
        end
    end

    assign host_rd_valid   = r_host_valid;
    assign host_rd_addr    = r_host_addr;
    assign host_rd_tag     = r_host_tag;
    assign pt_rx_rd_valid  = r_rx_valid;
    assign pt_rx_data      = r_rx_data;
    assign pt_rx_rd_tag    = r_rx_tag;
    assign outstanding_cnt = r_cnt;
    assign tag_error       = r_tag_error;

endmodule

// File: tb/tb_pt_rd_responder.sv
// tb/tb_pt_rd_responder.sv - self-checking bench for pt_rd_responder

`ifndef PAGETABLE_TAG
`define PAGETABLE_TAG [15:0]
`endif

module tb_pt_rd_responder;

    localparam int MAX  = 8;
    localparam int IDXW = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [31:0]         pt_tx_rd_addr;
    logic `PAGETABLE_TAG pt_tx_rd_tag;
    logic                pt_tx_rd_valid;
    logic                pt_tx_rd_ready;
    logic [255:0]        pt_rx_data;
    logic `PAGETABLE_TAG pt_rx_rd_tag;
    logic                pt_rx_rd_valid;
    logic [31:0]         host_rd_addr;
    logic [7:0]          host_rd_tag;
    logic                host_rd_valid;
    logic                host_rd_ready;
    logic [255:0]        host_rx_data;
    logic [7:0]          host_rx_tag;
    logic                host_rx_valid;
    logic [4:0]          outstanding_cnt;
    logic                tag_error;

    localparam int TW = $bits(pt_tx_rd_tag);

    always #5 clk = ~clk;

    pt_rd_responder #(.MAX_OUTSTANDING(MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .pt_tx_rd_addr(pt_tx_rd_addr), .pt_tx_rd_tag(pt_tx_rd_tag),
        .pt_tx_rd_valid(pt_tx_rd_valid), .pt_tx_rd_ready(pt_tx_rd_ready),
        .pt_rx_data(pt_rx_data), .pt_rx_rd_tag(pt_rx_rd_tag), .pt_rx_rd_valid(pt_rx_rd_valid),
        .host_rd_addr(host_rd_addr), .host_rd_tag(host_rd_tag),
        .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready),
        .host_rx_data(host_rx_data), .host_rx_tag(host_rx_tag), .host_rx_valid(host_rx_valid),
        .outstanding_cnt(outstanding_cnt), .tag_error(tag_error)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Transaction-level reference model.
    int                  m_cnt;
    bit                  m_hv;
    logic [31:0]         m_haddr;
    logic `PAGETABLE_TAG m_hptag;
    int                  m_hslot;
    bit                  m_busy [MAX];
    bit                  m_pend [MAX];
    bit                  m_have [MAX];
    logic [255:0]        m_data [MAX];
    logic `PAGETABLE_TAG m_ptag [MAX];
    int                  m_order[$];
    int                  m_issued[$];
    int                  m_seq;
    bit                  m_err;
    bit                  e_rv;
    logic [255:0]        e_rdata;
    logic `PAGETABLE_TAG e_rtag;

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic void model_clear();
        m_cnt = 0; m_hv = 0; m_haddr = '0; m_hptag = '0; m_hslot = 0;
        for (int i = 0; i < MAX; i++) begin
            m_busy[i] = 0; m_pend[i] = 0; m_have[i] = 0; m_data[i] = '0; m_ptag[i] = '0;
        end
        m_order.delete(); m_issued.delete();
        m_seq = 0; m_err = 0; e_rv = 0; e_rdata = '0; e_rtag = '0;
    endfunction

    function automatic void drop_issued(input int s);
        for (int k = 0; k < m_issued.size(); k++) begin
            if (m_issued[k] == s) begin
                m_issued.delete(k);
                break;
            end
        end
    endfunction

    // One clock of stimulus plus scoreboard comparison of every output.
    task automatic tick(input bit v, input logic [31:0] a, input logic `PAGETABLE_TAG t,
                        input bit hr, input bit rxv, input logic [7:0] rxt,
                        input logic [255:0] rxd, output bit acc);
        bit exp_rdy, hacc, rx_ok, ret, newreq;
        int ri, rslot, s;
        bit busy_before [MAX];
        logic [255:0] rdat;
        pt_tx_rd_valid = v; pt_tx_rd_addr = a; pt_tx_rd_tag = t;
        host_rd_ready = hr; host_rx_valid = rxv; host_rx_tag = rxt; host_rx_data = rxd;
        #1;
        exp_rdy = (m_cnt < MAX) && (!m_hv || hr);
        checks++;
        if (pt_tx_rd_ready !== exp_rdy) begin
            errors++; $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, pt_tx_rd_ready, exp_rdy);
        end
        acc  = v && exp_rdy;
        hacc = m_hv && hr;
        ri   = int'(rxt[IDXW-1:0]);
        rx_ok = rxv && (rxt[7:IDXW] == 0) && m_pend[ri];
        ret = 0; rslot = 0; rdat = '0;
`ifdef PT_RESP_REORDER_EN
        if (m_order.size() > 0 && m_have[m_order[0]]) begin
            ret = 1; rslot = m_order[0]; rdat = m_data[rslot];
        end
`else
        if (rx_ok) begin ret = 1; rslot = ri; rdat = rxd; end
`endif
        busy_before = m_busy;
        @(posedge clk); @(negedge clk); cyc++;
        if (rxv && !rx_ok) m_err = 1;
        e_rv = ret;
        if (ret) begin
            e_rdata = rdat; e_rtag = m_ptag[rslot];
            m_busy[rslot] = 0; m_pend[rslot] = 0; m_have[rslot] = 0; m_cnt--;
            for (int k = 0; k < m_order.size(); k++)
                if (m_order[k] == rslot) begin m_order.delete(k); break; end
        end
`ifdef PT_RESP_REORDER_EN
        if (rx_ok) begin m_pend[ri] = 0; m_have[ri] = 1; m_data[ri] = rxd; end
`endif
        if (acc) m_cnt++;
        if (hacc) m_issued.push_back(m_hslot);
        newreq = 0;
        if (acc) begin m_hv = 1; m_haddr = a; m_hptag = t; newreq = 1; end
        else if (hacc) m_hv = 0;

        checks++;
        if (outstanding_cnt !== 5'(m_cnt)) begin
            errors++; $display("FAIL cnt cyc=%0d got=%0d exp=%0d", cyc, outstanding_cnt, m_cnt);
        end
        checks++;
        if (tag_error !== m_err) begin
            errors++; $display("FAIL tag_error cyc=%0d got=%b exp=%b", cyc, tag_error, m_err);
        end
        checks++;
        if (pt_rx_rd_valid !== e_rv) begin
            errors++; $display("FAIL rx_valid cyc=%0d got=%b exp=%b", cyc, pt_rx_rd_valid, e_rv);
        end
        checks++;
        if (pt_rx_data !== e_rdata || pt_rx_rd_tag !== e_rtag) begin
            errors++; $display("FAIL rx_payload cyc=%0d got tag=%h data=%h exp tag=%h data=%h",
                               cyc, pt_rx_rd_tag, pt_rx_data, e_rtag, e_rdata);
        end
        checks++;
        if (host_rd_valid !== m_hv) begin
            errors++; $display("FAIL host_valid cyc=%0d got=%b exp=%b", cyc, host_rd_valid, m_hv);
        end
        if (m_hv) begin
            checks++;
            if (host_rd_addr !== m_haddr) begin
                errors++; $display("FAIL host_addr cyc=%0d got=%h exp=%h", cyc, host_rd_addr, m_haddr);
            end
            checks++;
            if (newreq) begin
                s = int'(host_rd_tag[IDXW-1:0]);
`ifdef PT_RESP_REORDER_EN
                if (host_rd_tag !== 8'(m_seq % MAX)) begin
                    errors++; $display("FAIL host_slot cyc=%0d got=%0d exp=%0d", cyc, host_rd_tag, m_seq % MAX);
                end
`else
                if (host_rd_tag >= 8'(MAX) || busy_before[s] || m_busy[s]) begin
                    errors++; $display("FAIL host_slot cyc=%0d got=%0d exp=a free slot", cyc, host_rd_tag);
                end
`endif
                m_seq++;
                m_busy[s] = 1; m_pend[s] = 1; m_ptag[s] = m_hptag;
                m_order.push_back(s); m_hslot = s;
            end else if (host_rd_tag !== 8'(m_hslot)) begin
                errors++; $display("FAIL host_tag_stable cyc=%0d got=%0d exp=%0d", cyc, host_rd_tag, m_hslot);
            end
        end
    endtask

    task automatic idle(input int n, input bit hr);
        bit acc;
        for (int i = 0; i < n; i++) tick(0, '0, '0, hr, 0, 8'd0, '0, acc);
    endtask

    task automatic do_reset();
        rst_n = 0;
        pt_tx_rd_valid = 0; host_rd_ready = 0; host_rx_valid = 0;
        @(negedge clk);
        rst_n = 1;
        model_clear();
    endtask

    task automatic drain();
        bit acc;
        int k, s;
        for (int i = 0; i < 300; i++) begin
            if (m_cnt == 0 && !m_hv) break;
            if (m_issued.size() > 0) begin
                k = $urandom_range(0, m_issued.size() - 1);
                s = m_issued[k];
                m_issued.delete(k);
                tick(0, '0, '0, 1, 1, 8'(s), rnd256(), acc);
            end else begin
                tick(0, '0, '0, 1, 0, 8'd0, '0, acc);
            end
        end
        idle(2, 1);
        checks++;
        if (m_cnt != 0 || m_hv) begin
            errors++; $display("FAIL drain_timeout got cnt=%0d exp=0", m_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        pt_tx_rd_valid = 0; pt_tx_rd_addr = '0; pt_tx_rd_tag = '0;
        host_rd_ready = 0; host_rx_valid = 0; host_rx_tag = '0; host_rx_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (pt_tx_rd_ready !== 1'b0 || host_rd_valid !== 1'b0 || pt_rx_rd_valid !== 1'b0 ||
            outstanding_cnt !== 5'd0 || tag_error !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl got rdy=%b hv=%b rv=%b cnt=%0d err=%b exp all 0",
                               pt_tx_rd_ready, host_rd_valid, pt_rx_rd_valid, outstanding_cnt, tag_error);
        end
        checks++;
        if (host_rd_addr !== '0 || host_rd_tag !== '0 || pt_rx_data !== '0 || pt_rx_rd_tag !== '0) begin
            errors++; $display("FAIL reset_data got addr=%h tag=%h rtag=%h exp 0", host_rd_addr, host_rd_tag, pt_rx_rd_tag);
        end
        rst_n = 1;
        model_clear();
        #1;
        checks++;
        if (pt_tx_rd_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset got=%b exp=1", pt_tx_rd_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        bit acc;
        int nv;
        logic [255:0] d0, seen;
        d0 = rnd256();
        tick(1, 32'h0000_1000, TW'(0), 1, 0, 8'd0, '0, acc);
        checks++;
        if (host_rd_valid !== 1'b1 || host_rd_addr !== 32'h0000_1000 || host_rd_tag !== 8'd0) begin
            errors++; $display("FAIL single_host got v=%b addr=%h tag=%0d exp v=1 addr=00001000 tag=0",
                               host_rd_valid, host_rd_addr, host_rd_tag);
        end
        idle(1, 1);
        drop_issued(0);
        tick(0, '0, '0, 1, 1, 8'd0, d0, acc);
        nv = 0; seen = '0;
        for (int i = 0; i < 4; i++) begin
            if (pt_rx_rd_valid === 1'b1) begin nv++; seen = pt_rx_data; end
            if (i < 3) idle(1, 1);
        end
        checks++;
        if (nv != 1 || seen !== d0 || pt_rx_rd_tag !== TW'(0)) begin
            errors++; $display("FAIL single_resp got n=%0d tag=%h data=%h exp n=1 tag=0 data=%h",
                               nv, pt_rx_rd_tag, seen, d0);
        end
    endtask

    task automatic test_fill();
        bit acc;
        int head;
        for (int i = 0; i < MAX; i++) tick(1, 32'h2000 + 32'(i * 64), TW'(i + 16), 1, 0, 8'd0, '0, acc);
        idle(1, 1);
        checks++;
        if (outstanding_cnt !== 5'd8 || pt_tx_rd_ready !== 1'b0) begin
            errors++; $display("FAIL fill_full got cnt=%0d rdy=%b exp cnt=8 rdy=0", outstanding_cnt, pt_tx_rd_ready);
        end
        head = m_order[0];
        drop_issued(head);
        tick(0, '0, '0, 1, 1, 8'(head), rnd256(), acc);
        for (int i = 0; i < 3; i++) begin
            if (pt_rx_rd_valid === 1'b1) break;
            idle(1, 1);
        end
        checks++;
        if (pt_rx_rd_valid !== 1'b1 || pt_tx_rd_ready !== 1'b1 || outstanding_cnt !== 5'd7) begin
            errors++; $display("FAIL fill_release got rv=%b rdy=%b cnt=%0d exp rv=1 rdy=1 cnt=7",
                               pt_rx_rd_valid, pt_tx_rd_ready, outstanding_cnt);
        end
        drain();
    endtask

    task automatic test_backpressure();
        bit acc;
        int n;
        tick(1, 32'hB000, TW'(7), 0, 0, 8'd0, '0, acc);
        for (int i = 0; i < 5; i++) begin
            tick(1, 32'hB040, TW'(8), 0, 0, 8'd0, '0, acc);
            checks++;
            if (pt_tx_rd_ready !== 1'b0 || host_rd_valid !== 1'b1 || host_rd_addr !== 32'hB000) begin
                errors++; $display("FAIL backpressure cyc=%0d got rdy=%b hv=%b addr=%h exp rdy=0 hv=1 addr=0000b000",
                                   cyc, pt_tx_rd_ready, host_rd_valid, host_rd_addr);
            end
        end
        n = 0; acc = 0;
        while (!acc && n < 5) begin
            tick(1, 32'hB040, TW'(8), 1, 0, 8'd0, '0, acc);
            n++;
        end
        checks++;
        if (!acc || host_rd_addr !== 32'hB040 || host_rd_valid !== 1'b1) begin
            errors++; $display("FAIL backpressure_resume got acc=%b addr=%h exp acc=1 addr=0000b040", acc, host_rd_addr);
        end
        drain();
    endtask

    task automatic test_order();
        bit acc;
        int slots[4];
        logic [255:0] d [4];
        int obs_cyc[$];
        logic [255:0] obs_dat[$];
        int c_first, c0, ok;
        do_reset();
        for (int i = 0; i < 4; i++) tick(1, 32'hA000 + 32'(i), TW'(1), 1, 0, 8'd0, '0, acc);
        idle(1, 1);
        for (int i = 0; i < 4; i++) begin slots[i] = m_order[i]; d[i] = rnd256(); end
        c_first = cyc; c0 = cyc + 3;
        for (int j = 3; j >= 0; j--) begin
            drop_issued(slots[j]);
            tick(0, '0, '0, 1, 1, 8'(slots[j]), d[j], acc);
            if (pt_rx_rd_valid === 1'b1) begin obs_cyc.push_back(cyc); obs_dat.push_back(pt_rx_data); end
        end
        for (int i = 0; i < 6; i++) begin
            idle(1, 1);
            if (pt_rx_rd_valid === 1'b1) begin obs_cyc.push_back(cyc); obs_dat.push_back(pt_rx_data); end
        end
        ok = (obs_cyc.size() == 4);
        for (int i = 0; i < 4 && ok; i++) begin
`ifdef PT_RESP_REORDER_EN
            if (obs_dat[i] !== d[i] || obs_cyc[i] != c0 + 2 + i) ok = 0;
`else
            if (obs_dat[i] !== d[3 - i] || obs_cyc[i] != c_first + 1 + i) ok = 0;
`endif
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL order got n=%0d first_cyc=%0d exp n=4 in expected order on consecutive cycles (start %0d/%0d)",
                               obs_cyc.size(), (obs_cyc.size() > 0) ? obs_cyc[0] : -1, c_first + 1, c0 + 2);
        end
        drain();
    endtask

    task automatic test_error();
        bit acc;
        tick(0, '0, '0, 1, 1, 8'h20, rnd256(), acc);
        tick(0, '0, '0, 1, 1, 8'd3, rnd256(), acc);
        checks++;
        if (tag_error !== 1'b1 || pt_rx_rd_valid !== 1'b0) begin
            errors++; $display("FAIL error_drop got err=%b rv=%b exp err=1 rv=0", tag_error, pt_rx_rd_valid);
        end
        for (int i = 0; i < 3; i++) begin
            idle(1, 1);
            checks++;
            if (tag_error !== 1'b1 || pt_rx_rd_valid !== 1'b0) begin
                errors++; $display("FAIL error_sticky got err=%b rv=%b exp err=1 rv=0", tag_error, pt_rx_rd_valid);
            end
        end
    endtask

    task automatic test_reset_midflight();
        bit acc;
        do_reset();
        for (int i = 0; i < 3; i++) tick(1, 32'hC000 + 32'(i * 64), TW'(i + 3), 1, 0, 8'd0, '0, acc);
        idle(1, 1);
        checks++;
        if (outstanding_cnt !== 5'd3) begin
            errors++; $display("FAIL midflight_pending got=%0d exp=3", outstanding_cnt);
        end
        rst_n = 0;
        pt_tx_rd_valid = 0; host_rx_valid = 0;
        #1;
        checks++;
        if (outstanding_cnt !== 5'd0 || pt_tx_rd_ready !== 1'b0) begin
            errors++; $display("FAIL midflight_reset got cnt=%0d rdy=%b exp cnt=0 rdy=0", outstanding_cnt, pt_tx_rd_ready);
        end
        @(negedge clk);
        rst_n = 1;
        model_clear();
        tick(0, '0, '0, 1, 1, 8'd0, rnd256(), acc);
        checks++;
        if (tag_error !== 1'b1 || outstanding_cnt !== 5'd0 || pt_rx_rd_valid !== 1'b0) begin
            errors++; $display("FAIL late_response got err=%b cnt=%0d rv=%b exp err=1 cnt=0 rv=0",
                               tag_error, outstanding_cnt, pt_rx_rd_valid);
        end
    endtask

    task automatic test_random();
        bit acc, pv, hr, rxv;
        logic [31:0] pa;
        logic `PAGETABLE_TAG pt;
        logic [7:0] rxt;
        int k;
        do_reset();
        pv = 0; pa = '0; pt = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pv && $urandom_range(0, 9) < 6) begin pv = 1; pa = $urandom; pt = TW'($urandom); end
            hr = ($urandom_range(0, 9) < 7);
            rxv = 0; rxt = 8'd0;
            if (m_issued.size() > 0 && $urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, m_issued.size() - 1);
                rxt = 8'(m_issued[k]);
                m_issued.delete(k);
                rxv = 1;
            end else if ($urandom_range(0, 24) == 0) begin
                rxt = {5'($urandom_range(1, 31)), 3'($urandom_range(0, 7))};
                rxv = 1;
            end
            tick(pv, pa, pt, hr, rxv, rxt, rnd256(), acc);
            if (acc) pv = 0;
        end
        drain();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_fill();
        test_backpressure();
        test_order();
        test_error();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
